// File: rtl/tm1638_pkg.sv
// tm1638_pkg: shared constants, enums and key-byte encoder for the TM1638 responder.
// Build option: define TM1638_RESPONDER_HCW132_KEYS_EN for the 16-key HCW132 key layout.
package tm1638_pkg;

    localparam logic [7:0] C_READ_KEYS  = 8'h42;
    localparam logic [7:0] C_WRITE_DISP = 8'h40;
    localparam logic [7:0] C_SET_ADDR_0 = 8'hC0;
    localparam logic [7:0] C_DISPLAY_ON = 8'h8F;

`ifdef TM1638_RESPONDER_HCW132_KEYS_EN
    localparam int KEY_W = 16;
`else
    localparam int KEY_W = 8;
`endif

    typedef enum logic [1:0] {
        CLS_NONE = 2'b00,
        CLS_DATA = 2'b01,
        CLS_DISP = 2'b10,
        CLS_ADDR = 2'b11
    } cmd_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    // Key-scan byte idx (0..3) as returned to the initiator; idx >= 4 reads as zero.
    function automatic logic [7:0] key_byte(input logic [KEY_W-1:0] k, input logic [2:0] idx);
        logic [7:0] b;
`ifdef TM1638_RESPONDER_HCW132_KEYS_EN
        logic [3:0] m;
        m = {1'b0, idx[1:0], 1'b0};
`else
        logic [2:0] j;
        j = {1'b0, idx[1:0]};
`endif
        b = '0;
        if (!idx[2]) begin
`ifdef TM1638_RESPONDER_HCW132_KEYS_EN
            b[2] = k[m];
            b[6] = k[m + 4'd1];
            b[1] = k[m + 4'd8];
            b[5] = k[m + 4'd9];
`else
            b[0] = k[3'd7 - j];
            b[4] = k[3'd3 - j];
`endif
        end
        return b;
    endfunction

endpackage

// File: rtl/tm1638_pin_sync.sv
// tm1638_pin_sync: 2-FF synchronizers and edge detect for the TM1638 serial pins.
// Ports: clk, rst (async, active low); sio_clk/sio_stb/sio_data_in raw pins;
//        clk_rise/clk_fall/stb_rise/stb_fall single-cycle edge pulses; data synchronized level.
module tm1638_pin_sync (
    input  logic clk,
    input  logic rst,
    input  logic sio_clk,
    input  logic sio_stb,
    input  logic sio_data_in,
    output logic clk_rise,
    output logic clk_fall,
    output logic stb_rise,
    output logic stb_fall,
    output logic data
);

    logic [2:0] clk_sh;
    logic [2:0] stb_sh;
    logic [1:0] dat_sh;

    // stb history resets low so a strobe already held low when reset releases
    // never looks like a fresh falling edge; only a spurious rise can appear, which is harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sh <= 3'b111;
            stb_sh <= 3'b000;
            dat_sh <= 2'b00;
        end else begin
            clk_sh <= {clk_sh[1:0], sio_clk};
            stb_sh <= {stb_sh[1:0], sio_stb};
            dat_sh <= {dat_sh[0], sio_data_in};
        end
    end

    assign clk_rise = clk_sh[1] & ~clk_sh[2];
    assign clk_fall = ~clk_sh[1] & clk_sh[2];
    assign stb_rise = stb_sh[1] & ~stb_sh[2];
    assign stb_fall = ~stb_sh[1] & stb_sh[2];
    assign data     = dat_sh[1];

endmodule

// File: rtl/tm1638_responder.sv
// tm1638_responder: TM1638 chip-side responder - decodes commands, holds display RAM, returns keys.
// Ports: clk, rst (async, active low); sio_clk/sio_stb/sio_data_in from initiator;
//        sio_data_out/sio_data_out_en read-data drive; keys live key levels;
//        ram 16-byte display RAM; display_on/brightness display control; ram_update write pulse.
// Build option: TM1638_RESPONDER_HCW132_KEYS_EN selects 16-bit keys with the HCW132 mapping.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int clk_mhz = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sio_clk,
    input  logic             sio_stb,
    input  logic             sio_data_in,
    output logic             sio_data_out,
    output logic             sio_data_out_en,
    input  logic [KEY_W-1:0] keys,
    output logic [127:0]     ram,
    output logic             display_on,
    output logic [2:0]       brightness,
    output logic             ram_update
);

    if (clk_mhz < 1) begin : g_clk_check
        $error("clk_mhz must be positive");
    end

    logic clk_rise, clk_fall, stb_rise, stb_fall, data;

    tm1638_pin_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .sio_clk    (sio_clk),
        .sio_stb    (sio_stb),
        .sio_data_in(sio_data_in),
        .clk_rise   (clk_rise),
        .clk_fall   (clk_fall),
        .stb_rise   (stb_rise),
        .stb_fall   (stb_fall),
        .data       (data)
    );

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [6:0]       rx_sh;
    logic [3:0]       ptr;
    logic             read_mode;
    logic             fixed_mode;
    logic [7:0]       tx_sh;
    logic [2:0]       tx_bit;
    logic [2:0]       tx_idx;
    logic [KEY_W-1:0] key_snap;
    logic [7:0]       nb;
    cmd_class_t       cls;

    // Byte as it stands once the bit currently being sampled is shifted in (LSB first).
    assign nb  = {data, rx_sh};
    assign cls = cmd_class_t'(nb[7:6]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            bit_cnt         <= '0;
            rx_sh           <= '0;
            ptr             <= '0;
            read_mode       <= 1'b0;
            fixed_mode      <= 1'b0;
            tx_sh           <= '0;
            tx_bit          <= '0;
            tx_idx          <= '0;
            key_snap        <= '0;
            ram             <= '0;
            display_on      <= 1'b0;
            brightness      <= '0;
            ram_update      <= 1'b0;
            sio_data_out    <= 1'b0;
            sio_data_out_en <= 1'b0;
        end else begin
            ram_update <= 1'b0;
            if (stb_fall) begin
                state   <= ST_CMD;
                bit_cnt <= '0;
                tx_bit  <= '0;
                tx_idx  <= '0;
            end else if (stb_rise) begin
                state           <= ST_IDLE;
                bit_cnt         <= '0;
                sio_data_out    <= 1'b0;
                sio_data_out_en <= 1'b0;
            end else if (state != ST_IDLE) begin
                if (clk_rise) begin
                    rx_sh   <= nb[7:1];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state == ST_CMD) begin
                            state <= ST_IGNORE;
                            if (cls == CLS_DATA) begin
                                read_mode  <= nb[1];
                                fixed_mode <= nb[2];
                                if (nb[1]) begin
                                    state    <= ST_RDATA;
                                    key_snap <= keys;
                                    tx_sh    <= key_byte(keys, 3'd0);
                                    tx_idx   <= 3'd1;
                                    tx_bit   <= '0;
                                end
                            end else if (cls == CLS_ADDR) begin
                                ptr <= nb[3:0];
                                if (!read_mode) state <= ST_WDATA;
                            end else if (cls == CLS_DISP) begin
                                display_on <= nb[3];
                                brightness <= nb[2:0];
                            end
                        end else if (state == ST_WDATA) begin
                            ram[{ptr, 3'b000} +: 8] <= nb;
                            ram_update              <= 1'b1;
                            if (!fixed_mode) ptr <= ptr + 4'd1;
                        end
                    end
                end
                // Each falling edge presents the next read bit; the next key byte loads after bit 7.
                if (clk_fall && state == ST_RDATA) begin
                    sio_data_out_en <= 1'b1;
                    sio_data_out    <= tx_sh[0];
                    tx_bit          <= tx_bit + 3'd1;
                    tx_sh           <= (tx_bit == 3'd7) ? key_byte(key_snap, tx_idx) : {1'b0, tx_sh[7:1]};
                    if (tx_bit == 3'd7) tx_idx <= (tx_idx == 3'd4) ? 3'd4 : tx_idx + 3'd1;
                end
            end
        end
    end

endmodule
